// File: rtl/ex_stage.sv
// ex_stage: integer execute stage fed by the ID/EX register.
// Single-cycle ALU/shift ops land in the EX/MEM output registers one clock
// after presentation; mult/div run an iterative 32-step engine into HI/LO
// while oStall holds the front of the pipe.
// Build option: define OVERFLOW_TRAP_EN to suppress the write and raise oOvf
// on signed overflow of add/sub class ops.
module ex_stage #(
    parameter int           W       = 32,
    parameter logic [W-1:0] DIVZ_LO = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         iRWrite,
    input  logic         iFloat,
    input  logic [1:0]   iWBsrc,
    input  logic         iMWrite,
    input  logic [2:0]   iExOp,
    input  logic [W-1:0] iRegOut1,
    input  logic [W-1:0] iRegOut2,
    input  logic [W-1:0] iRegOut3,
    input  logic [5:0]   iFun,
    input  logic [4:0]   iDstReg,
    input  logic [15:0]  iIm,
    output logic         oRWrite,
    output logic [1:0]   oWBsrc,
    output logic         oMWrite,
    output logic [W-1:0] oAluOut,
    output logic [W-1:0] oStoreData,
    output logic [4:0]   oDstReg,
    output logic         oStall,
    output logic         oOvf
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

    function automatic logic [W-1:0] negW(input logic neg, input logic [W-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] neg2W(input logic neg, input logic [2*W-1:0] v);
        return neg ? -v : v;
    endfunction

    mdState_t         state;
    logic [4:0]       cnt;
    logic [W-1:0]     hi, lo;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     opB;
    logic             isDiv, negQ, negR, divZ;

    // ---- stage p0: decode and single-cycle ALU on the ID/EX outputs ----
    logic signed [W-1:0] rs_p0, rt_p0, immS_p0;
    logic [W-1:0]        immZ_p0, sumRR_p0, difRR_p0, sumRI_p0, res_p0;
    logic [4:0]          shamt_p0;
    logic                legal_p0, ovf_p0, mdStart_p0, vld_p0, mdLoad_p0;
    logic                opAddRR_p0, opSub_p0, opAddRI_p0, mdSigned_p0;
    logic [W-1:0]        magA_p0, magB_p0;

    assign rs_p0       = iRegOut1;
    assign rt_p0       = iRegOut2;
    assign immS_p0     = {{(W-16){iIm[15]}}, iIm};
    assign immZ_p0     = {{(W-16){1'b0}}, iIm};
    assign shamt_p0    = iIm[10:6];
    assign sumRR_p0    = rs_p0 + rt_p0;
    assign difRR_p0    = rs_p0 - rt_p0;
    assign sumRI_p0    = rs_p0 + immS_p0;
    assign opAddRR_p0  = (iExOp == 3'b000) && (iFun == 6'h20);
    assign opSub_p0    = ((iExOp == 3'b000) && (iFun == 6'h22)) || (iExOp == 3'b110);
    assign opAddRI_p0  = (iExOp == 3'b001);
    assign mdStart_p0  = (iExOp == 3'b000) && !iFloat && (iFun[5:2] == 4'b0110);
    assign mdSigned_p0 = !iFun[0];
    assign magA_p0     = negW(mdSigned_p0 && iRegOut1[W-1], iRegOut1);
    assign magB_p0     = negW(mdSigned_p0 && iRegOut2[W-1], iRegOut2);

`ifdef OVERFLOW_TRAP_EN
    function automatic logic addOvf(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    function automatic logic subOvf(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] d);
        return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    endfunction

    assign ovf_p0 = (opAddRR_p0 && addOvf(iRegOut1, iRegOut2, sumRR_p0)) ||
                    (opSub_p0   && subOvf(iRegOut1, iRegOut2, difRR_p0)) ||
                    (opAddRI_p0 && addOvf(iRegOut1, immS_p0, sumRI_p0));
`else
    assign ovf_p0 = 1'b0;
`endif

    // While stalling or retiring a finished mult/div the stage emits a bubble
    assign oStall    = rstn && (((state == IDLE) && mdStart_p0) || (state == BUSY));
    assign vld_p0    = !(iFloat || oStall || (state == DONE));
    assign mdLoad_p0 = oStall && (state == IDLE);

    // Result select for every single-cycle op; unlisted functs yield 0 and no write
    always_comb begin
        res_p0   = '0;
        legal_p0 = 1'b1;
        case (iExOp)
            3'b000: begin
                case (iFun)
                    6'h20:   res_p0 = sumRR_p0;
                    6'h22:   res_p0 = difRR_p0;
                    6'h24:   res_p0 = iRegOut1 & iRegOut2;
                    6'h25:   res_p0 = iRegOut1 | iRegOut2;
                    6'h26:   res_p0 = iRegOut1 ^ iRegOut2;
                    6'h27:   res_p0 = ~(iRegOut1 | iRegOut2);
                    6'h2A:   res_p0 = {{(W-1){1'b0}}, (rs_p0 < rt_p0)};
                    6'h2B:   res_p0 = {{(W-1){1'b0}}, (iRegOut1 < iRegOut2)};
                    6'h00:   res_p0 = iRegOut2 << shamt_p0;
                    6'h02:   res_p0 = iRegOut2 >> shamt_p0;
                    6'h03:   res_p0 = rt_p0 >>> shamt_p0;
                    6'h10:   res_p0 = hi;
                    6'h12:   res_p0 = lo;
                    default: legal_p0 = 1'b0;
                endcase
            end
            3'b001:  res_p0 = sumRI_p0;
            3'b010:  res_p0 = iRegOut1 & immZ_p0;
            3'b011:  res_p0 = iRegOut1 | immZ_p0;
            3'b100:  res_p0 = {{(W-1){1'b0}}, (rs_p0 < immS_p0)};
            3'b101:  res_p0 = {iIm, 16'h0};
            3'b110:  res_p0 = difRR_p0;
            default: res_p0 = iRegOut1;
        endcase
    end

    // ---- stage p1: iterative mult/div engine ----
    logic [W:0]     mulSum_p1, divTrial_p1;
    logic [W-1:0]   divDiff_p1, hiRes_p1, loRes_p1;
    logic [2*W-1:0] mulNext_p1, divNext_p1, prod_p1;

    // One shift-add (mult) or restoring-subtract (div) step, plus final sign fix-up
    always_comb begin
        mulSum_p1   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opB} : '0);
        mulNext_p1  = {mulSum_p1, acc[W-1:1]};
        divTrial_p1 = acc[2*W-1:W-1];
        divDiff_p1  = divTrial_p1[W-1:0] - opB;
        if (divTrial_p1 >= {1'b0, opB}) divNext_p1 = {divDiff_p1, acc[W-2:0], 1'b1};
        else                            divNext_p1 = {acc[2*W-2:0], 1'b0};
        prod_p1  = neg2W(negQ, acc);
        hiRes_p1 = prod_p1[2*W-1:W];
        loRes_p1 = prod_p1[W-1:0];
        if (divZ) begin
            hiRes_p1 = acc[2*W-1:W];
            loRes_p1 = acc[W-1:0];
        end else if (isDiv) begin
            hiRes_p1 = negW(negR, acc[2*W-1:W]);
            loRes_p1 = negW(negQ, acc[W-1:0]);
        end
    end

    // Mult/div sequencer and HI/LO architectural state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: if (mdLoad_p0) begin
                    state <= BUSY;
                    cnt   <= '0;
                end
                BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DONE;
                end
                DONE: begin
                    hi    <= hiRes_p1;
                    lo    <= loRes_p1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture on start, then one engine step per BUSY cycle
    always_ff @(posedge clk) begin
        if (mdLoad_p0) begin
            isDiv <= iFun[1];
            negQ  <= mdSigned_p0 && (iRegOut1[W-1] ^ iRegOut2[W-1]);
            negR  <= mdSigned_p0 && iRegOut1[W-1];
            divZ  <= iFun[1] && (iRegOut2 == '0);
            opB   <= magB_p0;
            acc   <= (iFun[1] && (iRegOut2 == '0)) ? {iRegOut1, DIVZ_LO}
                                                  : {{W{1'b0}}, magA_p0};
        end else if ((state == BUSY) && !divZ) begin
            acc <= isDiv ? divNext_p1 : mulNext_p1;
        end
    end

    // ---- stage boundary: EX/MEM output register ----
    // Load the instruction's results, or a bubble when invalid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oRWrite    <= 1'b0;
            oWBsrc     <= '0;
            oMWrite    <= 1'b0;
            oAluOut    <= '0;
            oStoreData <= '0;
            oDstReg    <= '0;
            oOvf       <= 1'b0;
        end else if (!vld_p0) begin
            oRWrite    <= 1'b0;
            oWBsrc     <= '0;
            oMWrite    <= 1'b0;
            oAluOut    <= '0;
            oStoreData <= '0;
            oDstReg    <= '0;
            oOvf       <= 1'b0;
        end else begin
            oRWrite    <= iRWrite && legal_p0 && !ovf_p0;
            oWBsrc     <= iWBsrc;
            oMWrite    <= iMWrite;
            oAluOut    <= res_p0;
            oStoreData <= iRegOut3;
            oDstReg    <= iDstReg;
            oOvf       <= ovf_p0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a
// behavioural model using plain wide arithmetic for ALU, mult and div.
`timescale 1ns/1ps
module tb_ex_stage;

    localparam logic [31:0] DIVZ = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iRWrite, iFloat, iMWrite;
    logic [1:0]  iWBsrc;
    logic [2:0]  iExOp;
    logic [31:0] iRegOut1, iRegOut2, iRegOut3;
    logic [5:0]  iFun;
    logic [4:0]  iDstReg;
    logic [15:0] iIm;
    logic        oRWrite, oMWrite, oStall, oOvf;
    logic [1:0]  oWBsrc;
    logic [31:0] oAluOut, oStoreData;
    logic [4:0]  oDstReg;

    ex_stage dut (
        .clk(clk), .rstn(rstn), .iRWrite(iRWrite), .iFloat(iFloat), .iWBsrc(iWBsrc),
        .iMWrite(iMWrite), .iExOp(iExOp), .iRegOut1(iRegOut1), .iRegOut2(iRegOut2),
        .iRegOut3(iRegOut3), .iFun(iFun), .iDstReg(iDstReg), .iIm(iIm),
        .oRWrite(oRWrite), .oWBsrc(oWBsrc), .oMWrite(oMWrite), .oAluOut(oAluOut),
        .oStoreData(oStoreData), .oDstReg(oDstReg), .oStall(oStall), .oOvf(oOvf)
    );

    always #5 clk = ~clk;

    int          nVec = 0;
    int          nMis = 0;
    logic [31:0] mHi  = '0;
    logic [31:0] mLo  = '0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // true when a 64-bit signed result does not fit in 32 signed bits
    function automatic logic noFit(input longint t);
        logic [31:0] lowBits;
        lowBits = t[31:0];
        return t != longint'($signed(lowBits));
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [5:0] fn,
            input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
            output logic legal, output logic ovf);
        longint sa, sb, si, t;
        logic [31:0] r;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        si = longint'($signed(im));
        sh = int'(im[10:6]);
        legal = 1'b1; ovf = 1'b0; r = '0; t = 0;
        case (op)
            3'd0: case (fn)
                6'h20: begin t = sa + sb; r = t[31:0]; ovf = noFit(t); end
                6'h22: begin t = sa - sb; r = t[31:0]; ovf = noFit(t); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: begin t = sb >>> sh; r = t[31:0]; end
                6'h10: r = mHi;
                6'h12: r = mLo;
                default: legal = 1'b0;
            endcase
            3'd1: begin t = sa + si; r = t[31:0]; ovf = noFit(t); end
            3'd2: r = a & {16'h0, im};
            3'd3: r = a | {16'h0, im};
            3'd4: r = (sa < si) ? 32'd1 : 32'd0;
            3'd5: r = {im, 16'h0};
            3'd6: begin t = sa - sb; r = t[31:0]; ovf = noFit(t); end
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic void refMd(input logic [5:0] fn, input logic [31:0] a,
            input logic [31:0] b, output logic [31:0] hiV, output logic [31:0] loV);
        longint sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (fn)
            6'h18: p = sa * sb;
            6'h19: p = {32'h0, a} * {32'h0, b};
            6'h1A: if (b == 0) p = {a, DIVZ};
                   else begin q = sa / sb; rm = sa % sb; p = {rm[31:0], q[31:0]}; end
            default: if (b == 0) p = {a, DIVZ};
                     else p = {a % b, a / b};
        endcase
        hiV = p[63:32];
        loV = p[31:0];
    endfunction

    // present one single-cycle instruction (at posedge+1) and check its EX/MEM outputs
    task automatic applyVec(input string tag, input logic [2:0] op, input logic [5:0] fn,
            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
            input logic [15:0] im, input logic rw, input logic mw, input logic fl,
            input logic [1:0] wb, input logic [4:0] dst);
        logic [31:0] r;
        logic lg, ov, expOvf, expRw;
        iExOp = op; iFun = fn; iRegOut1 = a; iRegOut2 = b; iRegOut3 = c; iIm = im;
        iRWrite = rw; iMWrite = mw; iFloat = fl; iWBsrc = wb; iDstReg = dst;
        r = refAlu(op, fn, a, b, im, lg, ov);
`ifdef OVERFLOW_TRAP_EN
        expOvf = ov;
`else
        expOvf = 1'b0;
`endif
        expRw = rw && lg && !expOvf;
        #1;
        checkVal({tag, ".stall"}, 64'(oStall), 64'd0);
        @(posedge clk); #1;
        if (fl) begin
            checkVal({tag, ".ctl"}, 64'({oRWrite, oMWrite, oWBsrc, oDstReg, oOvf}), 64'd0);
            checkVal({tag, ".alu"}, 64'(oAluOut), 64'd0);
            checkVal({tag, ".st"}, 64'(oStoreData), 64'd0);
        end else begin
            checkVal({tag, ".ctl"}, 64'({oRWrite, oMWrite, oWBsrc, oDstReg, oOvf}),
                     64'({expRw, mw, wb, dst, expOvf}));
            checkVal({tag, ".alu"}, 64'(oAluOut), 64'(r));
            checkVal({tag, ".st"}, 64'(oStoreData), 64'(c));
        end
    endtask

    // run one mult/div from IDLE through DONE and the retire cycle
    task automatic mdRun(input string tag, input logic [5:0] fn, input logic [31:0] a,
            input logic [31:0] b);
        int n;
        logic [31:0] nh, nl;
        iExOp = 3'd0; iFun = fn; iRegOut1 = a; iRegOut2 = b; iRegOut3 = $urandom;
        iIm = 16'($urandom); iRWrite = 1'b1; iMWrite = 1'b0; iFloat = 1'b0;
        iWBsrc = 2'd1; iDstReg = 5'd3;
        refMd(fn, a, b, nh, nl);
        #1;
        n = 0;
        while (oStall && n < 100) begin
            n++;
            @(posedge clk); #1;
            checkVal({tag, ".bub"}, 64'({oRWrite, oMWrite, oAluOut}), 64'd0);
        end
        checkVal({tag, ".len"}, 64'(n), 64'd33);
        @(posedge clk); #1;
        checkVal({tag, ".ret"}, 64'({oRWrite, oMWrite}), 64'd0);
        mHi = nh;
        mLo = nl;
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] pickFun();
        logic [5:0] lst [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12};
        logic [5:0] f;
        if ($urandom_range(0, 3) == 0) f = 6'($urandom);
        else f = lst[$urandom_range(0, 12)];
        if (f[5:2] == 4'b0110) f = 6'h20;
        return f;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset with a mult held on the inputs: nothing may stall or leak out
        rstn = 1'b0;
        iExOp = 3'd0; iFun = 6'h18; iRegOut1 = 32'd3; iRegOut2 = 32'd4; iRegOut3 = 32'd9;
        iIm = 16'h1234; iRWrite = 1'b1; iMWrite = 1'b1; iFloat = 1'b0; iWBsrc = 2'd3;
        iDstReg = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst.stall", 64'(oStall), 64'd0);
        checkVal("rst.ctl", 64'({oRWrite, oMWrite, oWBsrc, oDstReg, oOvf}), 64'd0);
        checkVal("rst.data", {oAluOut, oStoreData}, 64'd0);
        iFun = 6'h00; iRWrite = 1'b0; iMWrite = 1'b0; iRegOut1 = '0; iRegOut2 = '0;
        iRegOut3 = '0; iIm = '0; iWBsrc = '0; iDstReg = '0;
        rstn = 1'b1;

        // all-zero bubble must not start the engine
        applyVec("zero", 3'd0, 6'h00, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0);
        applyVec("mfloRst", 3'd0, 6'h12, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);

        // directed single-cycle cases
        applyVec("add", 3'd0, 6'h20, 32'd5, 32'd7, 32'd1, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd8);
        checkVal("addLit", 64'(oAluOut), 64'd12);
        applyVec("sub", 3'd0, 6'h22, 32'd5, 32'd7, 32'd2, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd9);
        checkVal("subLit", 64'(oAluOut), 64'hFFFFFFFE);
        applyVec("addi", 3'd1, 6'h00, 32'h100, 32'd0, 32'h55, 16'hFFFC, 1'b0, 1'b1, 1'b0, 2'd1, 5'd0);
        checkVal("addiLit", 64'(oAluOut), 64'hFC);
        applyVec("lui", 3'd5, 6'h00, 32'd0, 32'd0, 32'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 2'd0, 5'd4);
        checkVal("luiLit", 64'(oAluOut), 64'h12340000);
        applyVec("sra", 3'd0, 6'h03, 32'd0, 32'h80000000, 32'd0, 16'(4 << 6), 1'b1, 1'b0, 1'b0,
                 2'd0, 5'd5);
        checkVal("sraLit", 64'(oAluOut), 64'hF8000000);
        applyVec("badFun", 3'd0, 6'h3F, 32'd1, 32'd2, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd6);
        applyVec("float", 3'd0, 6'h20, 32'd1, 32'd2, 32'd3, 16'd0, 1'b1, 1'b1, 1'b1, 2'd2, 5'd6);
        applyVec("ovf", 3'd0, 6'h20, 32'h7FFFFFFF, 32'd1, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd1);
`ifdef OVERFLOW_TRAP_EN
        checkVal("ovfLit", 64'({oOvf, oRWrite}), 64'b10);
`else
        checkVal("ovfLit", 64'({oOvf, oRWrite, oAluOut}), 64'({2'b01, 32'h80000000}));
`endif

        // signed multiply, then readback
        mdRun("mult", 6'h18, 32'hFFFFFFFD, 32'd7);
        applyVec("mflo", 3'd0, 6'h12, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        checkVal("mfloLit", 64'(oAluOut), 64'hFFFFFFEB);
        applyVec("mfhi", 3'd0, 6'h10, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        checkVal("mfhiLit", 64'(oAluOut), 64'hFFFFFFFF);

        // signed divide, then back-to-back divu by zero
        mdRun("div", 6'h1A, 32'hFFFFFFF9, 32'd2);
        mdRun("divuZ", 6'h1B, 32'd9, 32'd0);
        applyVec("mfhiZ", 3'd0, 6'h10, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        checkVal("mfhiZLit", 64'(oAluOut), 64'd9);
        applyVec("mfloZ", 3'd0, 6'h12, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        checkVal("mfloZLit", 64'(oAluOut), 64'hFFFFFFFF);
        mdRun("div2", 6'h1A, 32'hFFFFFFF9, 32'd2);
        applyVec("mflo2", 3'd0, 6'h12, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        checkVal("mflo2Lit", 64'(oAluOut), 64'hFFFFFFFD);
        applyVec("mfhi2", 3'd0, 6'h10, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        checkVal("mfhi2Lit", 64'(oAluOut), 64'hFFFFFFFF);

        // random single-cycle traffic
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            applyVec("rnd", op, pickFun(), pickVal(), pickVal(), $urandom, 16'($urandom),
                     1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                     2'($urandom), 5'($urandom));
        end

        // random mult/div with readback
        for (int i = 0; i < 8; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : pickVal();
            mdRun("rndMd", 6'(6'h18 + $urandom_range(0, 3)), pickVal(), b);
            applyVec("rndHi", 3'd0, 6'h10, $urandom, $urandom, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0,
                     2'd0, 5'd2);
            applyVec("rndLo", 3'd0, 6'h12, $urandom, $urandom, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0,
                     2'd0, 5'd2);
        end

        // reset in the middle of a multu: abort, HI/LO cleared
        mdRun("preRst", 6'h19, 32'h12345678, 32'h9ABCDEF1);
        iExOp = 3'd0; iFun = 6'h19; iRegOut1 = 32'hFFFFFFFF; iRegOut2 = 32'd2; iRWrite = 1'b1;
        #1;
        checkVal("rstMid.start", 64'(oStall), 64'd1);
        repeat (11) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkVal("rstMid.stall", 64'(oStall), 64'd0);
        checkVal("rstMid.out", 64'({oRWrite, oMWrite, oAluOut}), 64'd0);
        iFun = 6'h00; iRegOut1 = '0; iRegOut2 = '0; iRWrite = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        mHi = '0;
        mLo = '0;
        applyVec("rstHi", 3'd0, 6'h10, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);
        applyVec("rstLo", 3'd0, 6'h12, 32'd0, 32'd0, 32'd0, 16'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
